fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction fetch stage that sits directly upstream of the opcode decoder.
- Reads the opcode byte, then 0-2 operand bytes, from the single 8-bit memory bus, and maintains the program counter.
- Presents one complete instruction {opcode, operand, op_pc, length} to the decoder and sequencer through a valid/ready handshake.
- Handles PC redirects (jumps, branches, RTS/RTI) and injects BRK (opcode 8'h00) for pending interrupts at instruction boundaries.

Parameters:
RESET_PC, 16'h0000, PC value after reset; the sequencer redirects via pc_load after the vector fetch.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
rdy  in  1  memory ready; low stalls the bus cycle (6502 RDY semantics)
data_i  in  8  memory read data, valid in the same cycle addr_o is driven, sampled on the rising edge
addr_o  out  16  memory address
rd_o  out  1  read strobe
pc_load  in  1  redirect request
pc_load_val  in  16  redirect target
irq_req  in  1  interrupt pending (level)
instr_valid  out  1  instruction available
instr_ready  in  1  consumer accepts the instruction
opcode  out  8  fetched opcode, or 8'h00 if injected
operand  out  16  {hi, lo}; unused bytes are 0
op_pc  out  16  address of the opcode byte
instr_len  out  2  1, 2 or 3 bytes
is_int  out  1  opcode was injected for an interrupt
pc_o  out  16  next sequential PC (first byte after the instruction)

Behaviour:
- Reset values: state=S_OP, pc=RESET_PC, instr_valid=0, opcode=0, operand=0, op_pc=0, instr_len=0, is_int=0, rd_o=0.
  - Reset mid-operation discards any partial instruction.
- States: S_OP, S_LO, S_HI, S_VALID.
- addr_o:
  - pc in S_OP/S_LO/S_HI.
  - op_pc in S_VALID.
- rd_o: 1 in S_OP/S_LO/S_HI, 0 in S_VALID.
- S_OP, rdy=1:
  - If irq_req=1: opcode<=8'h00, is_int<=1, length=1, pc not incremented.
  - Else: opcode<=data_i, is_int<=0, pc<=pc+1.
  - In both cases op_pc<=pc, operand<=0.
  - Next state is S_VALID if length is 1, else S_LO.
- Length rule, from the byte just fetched:
  - 1 byte: 8'h00, 8'h40, 8'h60, or matches ???_?10_?0, or ???_000_10 with bit7=0 (JAM).
  - 3 bytes: 8'h20, or bbb=011, or bbb=111, or bbb=110 with bit0=1.
  - All others: 2 bytes.
- S_LO, rdy=1: operand[7:0]<=data_i, pc<=pc+1; next state is S_HI if length is 3, else S_VALID.
- S_HI, rdy=1: operand[15:8]<=data_i, pc<=pc+1 → S_VALID.
- rdy=0 in any fetch state: hold state, pc and address; data_i is ignored. rdy is ignored in S_VALID.
- S_VALID:
  - instr_valid=1.
  - Outputs are stable until accepted.
  - On instr_ready=1 → S_OP next cycle; instr_valid drops.
  - Latency for an n-byte instruction with no stalls: n fetch cycles + 1 valid cycle.
- irq_req is sampled only in S_OP; assertion during S_LO/S_HI/S_VALID has no effect until the next S_OP.
- pc_load=1 has priority over everything except rst, in any state, regardless of rdy:
  - pc<=pc_load_val, state<=S_OP, instr_valid<=0.
  - Any partial fetch is discarded.
  - If simultaneous with instr_ready, the instruction counts as consumed.
- PC arithmetic is 16-bit modulo; 16'hFFFF+1 wraps to 16'h0000, including mid-instruction operand fetch.
- pc_o is combinational: pc in S_VALID; the current pc elsewhere (informational).
- Never more than one instruction buffered; no prefetch beyond the current instruction.

Test Plan:
1. Reset, memory 0000:A9 42, instr_ready=1, rdy=1 → cycle 2 after reset: instr_valid=1, opcode=A9, operand=0042, instr_len=2, op_pc=0000, pc_o=0002; next S_OP reads 0002.
2. Memory 0002:8D 00 02, then 0005:E8 → opcode 8D, operand 0200, len 3, op_pc 0002; then E8, len 1, operand 0000, op_pc 0005, valid one cycle after its fetch.
3. rdy=0 for 3 cycles during S_LO of A9 42 → addr_o held at pc of the operand, rd_o=1, valid delayed 3 cycles, operand still 0042. Hold instr_ready=0 for 4 cycles in S_VALID → outputs stable, no reads.
4. pc_load=1, pc_load_val=1234 during S_HI of a 3-byte fetch → next cycle addr_o=1234 in S_OP, instr_valid=0, no instruction emitted for the aborted fetch.
5. irq_req=1 during S_LO; instruction completes normally; at the next S_OP → opcode=00, is_int=1, len=1, op_pc = boundary address, pc unchanged. irq_req=1 exactly at S_OP → same result, with data_i ignored.
6. pc=FFFE holding AD at FFFE, 34 at FFFF, 12 at 0000 → operand 1234, op_pc FFFE, pc_o 0001. Assert rst during S_LO → all outputs at reset values, next fetch at RESET_PC.

Source files
------------

// File: rtl/fetch_unit_if.sv
// Memory bus and instruction handshake between the fetch stage, memory and decoder.
// The fetch unit is the master; memory/decoder side uses the slave modport.
interface fetch_unit_if;
    logic        rdy;
    logic [7:0]  data_i;
    logic [15:0] addr_o;
    logic        rd_o;

    logic        instr_valid;
    logic        instr_ready;
    logic [7:0]  opcode;
    logic [15:0] operand;
    logic [15:0] op_pc;
    logic [1:0]  instr_len;
    logic        is_int;

    modport master (
        input  rdy,
        input  data_i,
        input  instr_ready,
        output addr_o,
        output rd_o,
        output instr_valid,
        output opcode,
        output operand,
        output op_pc,
        output instr_len,
        output is_int
    );

    modport slave (
        output rdy,
        output data_i,
        output instr_ready,
        input  addr_o,
        input  rd_o,
        input  instr_valid,
        input  opcode,
        input  operand,
        input  op_pc,
        input  instr_len,
        input  is_int
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: reads opcode plus 0-2 operand bytes over an 8-bit bus and
// hands one complete instruction at a time to the decoder via valid/ready.
module fetch_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic                clk,
    input  logic                rst,
    fetch_unit_if.master        bus,
    input  logic                pc_load,
    input  logic [15:0]         pc_load_val,
    input  logic                irq_req,
    output logic [15:0]         pc_o
);

    typedef enum logic [1:0] {
        S_OP    = 2'd0,
        S_LO    = 2'd1,
        S_HI    = 2'd2,
        S_VALID = 2'd3
    } state_t;

    state_t      state;
    logic [15:0] pc;
    logic [15:0] op_pc;
    logic [7:0]  opcode;
    logic [15:0] operand;
    logic [1:0]  instr_len;
    logic        is_int;
    logic        instr_valid;
    logic [1:0]  fetch_len;

    // Instruction length from the opcode byte (6502 aaa_bbb_cc layout).
    function automatic logic [1:0] decode_len(input logic [7:0] b);
        logic [1:0] len;
        len = 2'd2;
        if (b == 8'h00 || b == 8'h40 || b == 8'h60)
            len = 2'd1;
        else if (b[3:2] == 2'b10 && !b[0])
            len = 2'd1;
        else if (b[4:0] == 5'b000_10 && !b[7])
            len = 2'd1;
        else if (b == 8'h20 || b[4:2] == 3'b011 || b[4:2] == 3'b111 ||
                 (b[4:2] == 3'b110 && b[0]))
            len = 2'd3;
        return len;
    endfunction

    assign fetch_len = decode_len(bus.data_i);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_OP;
            pc          <= RESET_PC;
            instr_valid <= 1'b0;
            opcode      <= 8'h00;
            operand     <= 16'h0000;
            op_pc       <= 16'h0000;
            instr_len   <= 2'd0;
            is_int      <= 1'b0;
        end else if (pc_load) begin
            // Redirect wins over everything; a partial fetch is simply dropped.
            pc          <= pc_load_val;
            state       <= S_OP;
            instr_valid <= 1'b0;
        end else begin
            case (state)
                S_OP: begin
                    if (bus.rdy) begin
                        op_pc   <= pc;
                        operand <= 16'h0000;
                        if (irq_req) begin
                            // Injected BRK: pc stays at the boundary so RTI returns here.
                            opcode      <= 8'h00;
                            is_int      <= 1'b1;
                            instr_len   <= 2'd1;
                            state       <= S_VALID;
                            instr_valid <= 1'b1;
                        end else begin
                            opcode    <= bus.data_i;
                            is_int    <= 1'b0;
                            instr_len <= fetch_len;
                            pc        <= pc + 16'd1;
                            if (fetch_len == 2'd1) begin
                                state       <= S_VALID;
                                instr_valid <= 1'b1;
                            end else begin
                                state <= S_LO;
                            end
                        end
                    end
                end
                S_LO: begin
                    if (bus.rdy) begin
                        operand[7:0] <= bus.data_i;
                        pc           <= pc + 16'd1;
                        if (instr_len == 2'd3) begin
                            state <= S_HI;
                        end else begin
                            state       <= S_VALID;
                            instr_valid <= 1'b1;
                        end
                    end
                end
                S_HI: begin
                    if (bus.rdy) begin
                        operand[15:8] <= bus.data_i;
                        pc            <= pc + 16'd1;
                        state         <= S_VALID;
                        instr_valid   <= 1'b1;
                    end
                end
                S_VALID: begin
                    if (bus.instr_ready) begin
                        state       <= S_OP;
                        instr_valid <= 1'b0;
                    end
                end
                default: begin
                    state       <= S_OP;
                    instr_valid <= 1'b0;
                end
            endcase
        end
    end

    // While holding an instruction the bus idles on its opcode address.
    assign bus.addr_o      = (state == S_VALID) ? op_pc : pc;
    assign bus.rd_o        = !rst && (state != S_VALID);
    assign bus.instr_valid = instr_valid;
    assign bus.opcode      = opcode;
    assign bus.operand     = operand;
    assign bus.op_pc       = op_pc;
    assign bus.instr_len   = instr_len;
    assign bus.is_int      = is_int;
    assign pc_o            = pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: table-driven program run plus directed stall, redirect,
// interrupt, wrap and reset sequences, checked through an expected-instruction queue.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pc_load = 1'b0;
    logic [15:0] pc_load_val = 16'h0000;
    logic        irq_req = 1'b0;
    logic [15:0] pc_o;

    fetch_unit_if bus ();

    logic [7:0] mem [0:65535];
    assign bus.data_i = mem[bus.addr_o];

    fetch_unit #(.RESET_PC(16'h0000)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .pc_load    (pc_load),
        .pc_load_val(pc_load_val),
        .irq_req    (irq_req),
        .pc_o       (pc_o)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc;

    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    typedef struct {
        logic [7:0]  opc;
        logic [15:0] opnd;
        logic [15:0] oppc;
        logic [1:0]  len;
        logic        intr;
        logic [15:0] npc;
        int          cyc;
    } exp_t;

    typedef struct {
        logic [7:0]  b0;
        logic [7:0]  b1;
        logic [7:0]  b2;
        logic [1:0]  len;
        logic [15:0] opnd;
    } vec_t;

    exp_t sb[$];
    vec_t tbl[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic push_exp(input logic [7:0] o, input logic [15:0] d, input logic [15:0] p,
                            input logic [1:0] l, input logic i, input logic [15:0] n, input int c);
        exp_t e;
        e.opc = o; e.opnd = d; e.oppc = p; e.len = l; e.intr = i; e.npc = n; e.cyc = c;
        sb.push_back(e);
    endtask

    // Each accepted instruction is compared against the head of the queue.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && bus.instr_valid && bus.instr_ready) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_instr: got opcode %h op_pc %h want none", bus.opcode, bus.op_pc);
            end else begin
                e = sb.pop_front();
                check("opcode",    bus.opcode,    e.opc);
                check("operand",   bus.operand,   e.opnd);
                check("op_pc",     bus.op_pc,     e.oppc);
                check("instr_len", bus.instr_len, e.len);
                check("is_int",    bus.is_int,    e.intr);
                check("pc_o",      pc_o,          e.npc);
                if (e.cyc >= 0) check("latency", cyc, e.cyc);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic redirect(input logic [15:0] a);
        pc_load_val = a;
        pc_load     = 1'b1;
        step();
        pc_load     = 1'b0;
    endtask

    task automatic wait_empty(input int limit);
        int n;
        n = 0;
        while (sb.size() != 0 && n < limit) begin
            @(negedge clk);
            n++;
        end
        check("drain", sb.size(), 0);
        step();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"},   bus.instr_valid, 1'b0);
        check({tag, "_opcode"},  bus.opcode,      8'h00);
        check({tag, "_operand"}, bus.operand,     16'h0000);
        check({tag, "_op_pc"},   bus.op_pc,       16'h0000);
        check({tag, "_len"},     bus.instr_len,   2'd0);
        check({tag, "_is_int"},  bus.is_int,      1'b0);
        check({tag, "_rd"},      bus.rd_o,        1'b0);
        check({tag, "_pc"},      pc_o,            16'h0000);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] a;
        int          c;

        tbl[0]  = '{8'hA9, 8'h42, 8'h00, 2'd2, 16'h0042};
        tbl[1]  = '{8'h8D, 8'h00, 8'h02, 2'd3, 16'h0200};
        tbl[2]  = '{8'hE8, 8'h00, 8'h00, 2'd1, 16'h0000};
        tbl[3]  = '{8'h4C, 8'h34, 8'h12, 2'd3, 16'h1234};
        tbl[4]  = '{8'h20, 8'h78, 8'h56, 2'd3, 16'h5678};
        tbl[5]  = '{8'h60, 8'h00, 8'h00, 2'd1, 16'h0000};
        tbl[6]  = '{8'h40, 8'h00, 8'h00, 2'd1, 16'h0000};
        tbl[7]  = '{8'h00, 8'h00, 8'h00, 2'd1, 16'h0000};
        tbl[8]  = '{8'h02, 8'h00, 8'h00, 2'd1, 16'h0000};
        tbl[9]  = '{8'hA2, 8'h05, 8'h00, 2'd2, 16'h0005};
        tbl[10] = '{8'h99, 8'hCD, 8'hAB, 2'd3, 16'hABCD};
        tbl[11] = '{8'h98, 8'h00, 8'h00, 2'd1, 16'h0000};
        tbl[12] = '{8'h0A, 8'h00, 8'h00, 2'd1, 16'h0000};
        tbl[13] = '{8'hB1, 8'h10, 8'h00, 2'd2, 16'h0010};
        tbl[14] = '{8'h1F, 8'h11, 8'h22, 2'd3, 16'h2211};
        tbl[15] = '{8'hF0, 8'hFE, 8'h00, 2'd2, 16'h00FE};

        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        bus.rdy         = 1'b1;
        bus.instr_ready = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check_reset_outputs("reset");

        // Back-to-back program from RESET_PC with expected valid cycles.
        a = 16'h0000;
        c = -1;
        for (int i = 0; i < 16; i++) begin
            mem[a] = tbl[i].b0;
            if (tbl[i].len >= 2'd2) mem[a + 16'd1] = tbl[i].b1;
            if (tbl[i].len == 2'd3) mem[a + 16'd2] = tbl[i].b2;
            c = c + int'(tbl[i].len) + 1;
            push_exp(tbl[i].b0, tbl[i].opnd, a, tbl[i].len, 1'b0, a + 16'(tbl[i].len), c);
            a = a + 16'(tbl[i].len);
        end
        bus.instr_ready = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        check("c0_addr", bus.addr_o, 16'h0000);
        check("c0_rd", bus.rd_o, 1'b1);
        check("c0_valid", bus.instr_valid, 1'b0);
        @(negedge clk);
        check("c1_addr", bus.addr_o, 16'h0001);
        @(negedge clk);
        check("c2_valid", bus.instr_valid, 1'b1);
        check("c2_addr", bus.addr_o, 16'h0000);
        check("c2_rd", bus.rd_o, 1'b0);
        @(negedge clk);
        check("c3_addr", bus.addr_o, 16'h0002);
        check("c3_rd", bus.rd_o, 1'b1);
        check("c3_valid", bus.instr_valid, 1'b0);
        step();
        wait_empty(400);
        bus.instr_ready = 1'b0;

        // rdy stall in S_LO, then consumer back-pressure in S_VALID.
        mem[16'h0100] = 8'hA9; mem[16'h0101] = 8'h42; mem[16'h0102] = 8'hEA;
        push_exp(8'hA9, 16'h0042, 16'h0100, 2'd2, 1'b0, 16'h0102, -1);
        redirect(16'h0100);
        step();
        bus.rdy = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("stall_addr", bus.addr_o, 16'h0101);
            check("stall_rd", bus.rd_o, 1'b1);
            check("stall_valid", bus.instr_valid, 1'b0);
            step();
        end
        bus.rdy = 1'b1;
        @(negedge clk);
        check("stall_end_valid", bus.instr_valid, 1'b0);
        step();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("hold_valid", bus.instr_valid, 1'b1);
            check("hold_opcode", bus.opcode, 8'hA9);
            check("hold_operand", bus.operand, 16'h0042);
            check("hold_rd", bus.rd_o, 1'b0);
            check("hold_addr", bus.addr_o, 16'h0100);
            step();
        end
        bus.instr_ready = 1'b1;
        wait_empty(10);
        bus.instr_ready = 1'b0;

        // Redirect during S_HI aborts the 3-byte fetch.
        mem[16'h0200] = 8'h8D; mem[16'h0201] = 8'h00; mem[16'h0202] = 8'h02;
        mem[16'h1234] = 8'hE8;
        redirect(16'h0200);
        step();
        step();
        @(negedge clk);
        check("abort_hi_addr", bus.addr_o, 16'h0202);
        pc_load_val = 16'h1234;
        pc_load     = 1'b1;
        step();
        pc_load = 1'b0;
        @(negedge clk);
        check("abort_addr", bus.addr_o, 16'h1234);
        check("abort_rd", bus.rd_o, 1'b1);
        check("abort_valid", bus.instr_valid, 1'b0);
        push_exp(8'hE8, 16'h0000, 16'h1234, 2'd1, 1'b0, 16'h1235, -1);
        step();
        bus.instr_ready = 1'b1;
        wait_empty(10);
        bus.instr_ready = 1'b0;

        // irq raised mid-instruction takes effect at the next boundary.
        mem[16'h0300] = 8'hA9; mem[16'h0301] = 8'h42; mem[16'h0302] = 8'h55; mem[16'h0303] = 8'h11;
        push_exp(8'hA9, 16'h0042, 16'h0300, 2'd2, 1'b0, 16'h0302, -1);
        push_exp(8'h00, 16'h0000, 16'h0302, 2'd1, 1'b1, 16'h0302, -1);
        redirect(16'h0300);
        bus.instr_ready = 1'b1;
        step();
        irq_req = 1'b1;
        wait_empty(10);
        irq_req = 1'b0;
        bus.instr_ready = 1'b0;

        // irq already pending when S_OP starts; memory byte is ignored.
        mem[16'h0400] = 8'h55; mem[16'h0401] = 8'h77;
        irq_req = 1'b1;
        redirect(16'h0400);
        push_exp(8'h00, 16'h0000, 16'h0400, 2'd1, 1'b1, 16'h0400, -1);
        bus.instr_ready = 1'b1;
        wait_empty(10);
        irq_req = 1'b0;
        bus.instr_ready = 1'b0;

        // Operand fetch across the 16-bit wrap.
        mem[16'hFFFE] = 8'hAD; mem[16'hFFFF] = 8'h34; mem[16'h0000] = 8'h12;
        push_exp(8'hAD, 16'h1234, 16'hFFFE, 2'd3, 1'b0, 16'h0001, -1);
        redirect(16'hFFFE);
        bus.instr_ready = 1'b1;
        wait_empty(10);
        bus.instr_ready = 1'b0;

        // Reset during S_LO discards the partial instruction.
        mem[16'h0500] = 8'hA9; mem[16'h0501] = 8'h42;
        redirect(16'h0500);
        step();
        rst = 1'b1;
        step();
        @(negedge clk);
        check_reset_outputs("midreset");
        step();
        rst = 1'b0;
        @(negedge clk);
        check("post_reset_addr", bus.addr_o, 16'h0000);
        check("post_reset_rd", bus.rd_o, 1'b1);
        step();
        step();

        check("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
